// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration path: register map, SPI frame
// layout and controller state encoding.
package pwm_cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT          = 7'h00;
  localparam logic [6:0] ADDR_EN_PWM_OUT      = 7'h01;
  localparam logic [6:0] ADDR_OUT_3_0_CH      = 7'h02;
  localparam logic [6:0] ADDR_OUT_7_4_CH      = 7'h03;
  localparam logic [6:0] ADDR_G0_CH0_DUTY     = 7'h04;
  localparam logic [6:0] ADDR_G0_CH1_DUTY     = 7'h05;
  localparam logic [6:0] ADDR_G1_CH0_DUTY     = 7'h06;
  localparam logic [6:0] ADDR_G1_CH1_DUTY     = 7'h07;
  localparam logic [6:0] ADDR_PWM_FREQ_DIV    = 7'h08;

  localparam int   NUM_REGS       = 9;
  localparam int   SPI_FRAME_BITS = 16;
  localparam logic SPI_RW_WRITE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a history flop for
// edge detection; level/rise/fall are valid STAGES clk edges after the pin.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_config_controller.sv
// SPI-slave (mode 0, write-only) that programs the nine pwm_peripheral config
// registers; a frame commits SYNC_STAGES+2 clk edges after the ncs pin rises.
module spi_config_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_copi,
  input  logic       spi_ncs,
  output logic [7:0] reg_en_out,
  output logic [7:0] reg_en_pwm_out,
  output logic [7:0] reg_out_3_0_pwm_gen_channel,
  output logic [7:0] reg_out_7_4_pwm_gen_channel,
  output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
  output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
  output logic [7:0] reg_pwm_gen_1_0_frequency_divider,
  output logic       cfg_update,
  output logic [6:0] cfg_addr
);
  import pwm_cfg_pkg::*;

  localparam int         NUM_OUT_REGS = 9;
  localparam logic [4:0] FRAME_CNT    = 5'(SPI_FRAME_BITS);
  localparam logic [7:0] ADDR_LIMIT   = 8'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise, copi_fall;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .async_i(spi_sclk),
    .sync_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .async_i(spi_ncs),
    .sync_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );

  // Same depth as sclk so data and clock arrive with no relative skew.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .async_i(spi_copi),
    .sync_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
  );

  assign unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [15:0] shift_q;
  logic        ovf_q;
  logic [7:0]  regs_q [NUM_OUT_REGS];
  logic        commit_ok;

  assign commit_ok = (cnt_q == FRAME_CNT) && !ovf_q &&
                     (shift_q[15] == SPI_RW_WRITE) &&
                     ({1'b0, shift_q[14:8]} < ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ovf_q      <= 1'b0;
      cfg_update <= 1'b0;
      cfg_addr   <= '0;
      for (int i = 0; i < NUM_OUT_REGS; i++) regs_q[i] <= '0;
    end else begin
      cfg_update <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncs_fall) begin
            cnt_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // ncs rise takes priority over a coincident sclk edge.
          if (ncs_rise) begin
            state_q <= COMMIT;
          end else if (ncs_fall) begin
            cnt_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
          end else if (sclk_rise && !ncs_lvl) begin
            shift_q <= {shift_q[14:0], copi_lvl};
            if (cnt_q == FRAME_CNT) ovf_q <= 1'b1;
            else                    cnt_q <= cnt_q + 5'd1;
          end
        end
        COMMIT: begin
          if (commit_ok) begin
            for (int i = 0; i < NUM_OUT_REGS; i++) begin
              if (shift_q[14:8] == 7'(i)) regs_q[i] <= shift_q[7:0];
            end
            cfg_addr   <= shift_q[14:8];
            cfg_update <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_en_out                        = regs_q[0];
  assign reg_en_pwm_out                    = regs_q[1];
  assign reg_out_3_0_pwm_gen_channel       = regs_q[2];
  assign reg_out_7_4_pwm_gen_channel       = regs_q[3];
  assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[4];
  assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[5];
  assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[6];
  assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[7];
  assign reg_pwm_gen_1_0_frequency_divider = regs_q[8];

endmodule

// File: tb/tb_spi_config_controller.sv
// Directed bench for spi_config_controller: a reference register map plus a
// queue of expected commits checked against every cfg_update pulse.
module tb_spi_config_controller;
  import pwm_cfg_pkg::*;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_copi = 1'b0;
  logic       spi_ncs = 1'b1;
  logic [7:0] reg_en_out, reg_en_pwm_out, reg_out_3_0, reg_out_7_4;
  logic [7:0] duty00, duty01, duty10, duty11, freq_div;
  logic       cfg_update;
  logic [6:0] cfg_addr;

  spi_config_controller #(.SYNC_STAGES(SYNC), .NUM_REGS(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_copi(spi_copi), .spi_ncs(spi_ncs),
    .reg_en_out(reg_en_out),
    .reg_en_pwm_out(reg_en_pwm_out),
    .reg_out_3_0_pwm_gen_channel(reg_out_3_0),
    .reg_out_7_4_pwm_gen_channel(reg_out_7_4),
    .reg_pwm_gen_0_ch_0_duty_cycle(duty00),
    .reg_pwm_gen_0_ch_1_duty_cycle(duty01),
    .reg_pwm_gen_1_ch_0_duty_cycle(duty10),
    .reg_pwm_gen_1_ch_1_duty_cycle(duty11),
    .reg_pwm_gen_1_0_frequency_divider(freq_div),
    .cfg_update(cfg_update),
    .cfg_addr(cfg_addr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  logic [14:0] sb_q [$];
  logic [7:0]  exp_regs [9];
  logic [6:0]  exp_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input logic [6:0] a);
    case (a)
      ADDR_EN_OUT:       return reg_en_out;
      ADDR_EN_PWM_OUT:   return reg_en_pwm_out;
      ADDR_OUT_3_0_CH:   return reg_out_3_0;
      ADDR_OUT_7_4_CH:   return reg_out_7_4;
      ADDR_G0_CH0_DUTY:  return duty00;
      ADDR_G0_CH1_DUTY:  return duty01;
      ADDR_G1_CH0_DUTY:  return duty10;
      ADDR_G1_CH1_DUTY:  return duty11;
      ADDR_PWM_FREQ_DIV: return freq_div;
      default:           return 8'hxx;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [16:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_copi = val[i];
      idle(2);
      spi_sclk = 1'b1;
      idle(4);
      spi_sclk = 1'b0;
      idle(2);
    end
  endtask

  // Reference decision: only a complete 16-bit write to an implemented address lands.
  task automatic send_frame(input logic [16:0] val, input int nbits);
    if (nbits == 16 && val[15] == 1'b1 && val[14:8] < 7'd9) begin
      sb_q.push_back(val[14:0]);
      exp_regs[val[14:8]] = val[7:0];
      exp_addr = val[14:8];
      exp_pulses++;
    end
    spi_ncs = 1'b0;
    idle(4);
    send_bits(val, nbits);
    spi_ncs = 1'b1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_reg%0d", tag, i), dut_reg(7'(i)), exp_regs[i]);
    check({tag, "_cfg_addr"}, cfg_addr, exp_addr);
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_update) begin
      logic [14:0] e;
      pulses++;
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", cfg_update, 1'b0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_addr", cfg_addr, e[14:8]);
        check("pulse_data", dut_reg(cfg_addr), e[7:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    idle(3);
    check_all("reset");
    check("reset_update", cfg_update, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // 1: single write with latency check
    send_frame(17'h080F0, 16);
    idle(SYNC + 1);
    check("t1_pre_update", cfg_update, 1'b0);
    check("t1_pre_reg", reg_en_out, 8'h00);
    idle(1);
    check("t1_update", cfg_update, 1'b1);
    check("t1_reg", reg_en_out, 8'hF0);
    idle(1);
    check("t1_pulse_width", cfg_update, 1'b0);
    idle(6);
    check_all("t1");

    // 2: back-to-back writes with short ncs high time
    send_frame(17'h08455, 16);
    idle(4);
    send_frame(17'h088A3, 16);
    idle(10);
    check_all("t2");
    check("t2_duty", duty00, 8'h55);
    check("t2_freq", freq_div, 8'hA3);

    // 3: read frame and out-of-range address are discarded
    send_frame(17'h004AA, 16);
    idle(8);
    send_frame(17'h08912, 16);
    idle(10);
    check_all("t3");

    // 4: short and long frames discarded, then a good one lands
    send_frame(17'h08177 >> 1, 15);
    idle(8);
    send_frame({16'h8177, 1'b0}, 17);
    idle(10);
    check("t4_bad_len", reg_en_pwm_out, 8'h00);
    send_frame(17'h08177, 16);
    idle(10);
    check_all("t4");

    // 5: reset in the middle of a frame
    send_frame(17'h083C3, 16);
    idle(10);
    check("t5_before", reg_out_7_4, 8'hC3);
    spi_ncs = 1'b0;
    idle(4);
    send_bits(17'h083C3 >> 8, 8);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
    exp_addr = '0;
    check_all("t5_reset");
    check("t5_reset_update", cfg_update, 1'b0);
    @(negedge clk);
    spi_ncs = 1'b1;
    spi_sclk = 1'b0;
    idle(4);
    rst_n = 1'b1;
    idle(4);
    send_frame(17'h083C3, 16);
    idle(10);
    check_all("t5_after");

    // 6: sclk toggling with ncs high is ignored
    for (int i = 0; i < 10; i++) begin
      spi_copi = 1'($urandom);
      idle(2);
      spi_sclk = 1'b1;
      idle(4);
      spi_sclk = 1'b0;
      idle(2);
    end
    idle(4);
    check("t6_idle_update", pulses, exp_pulses);
    send_frame(17'h08201, 16);
    idle(10);
    check_all("t6");

    check("sb_drained", sb_q.size(), 0);
    check("pulse_count", pulses, exp_pulses);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
